// File: rtl/mdu_hilo_unit.sv
// Multi-cycle mult/multu/div/divu unit owning the HI/LO registers (mfhi/mflo read port, mthi/mtlo writes).
// Latency: mult/multu hold busy MULT_CYCLES cycles, div/divu DIV_CYCLES cycles; mthi/mtlo land in one cycle.
// Backpressure: no queueing; a start while busy is dropped, so the issuing stage must stall on busy.
module mdu_hilo_unit #(
   parameter int WIDTH       = 32,
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       mdu_op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             rd_sel,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo,
   output logic [WIDTH-1:0] rd_data
);

   typedef enum logic [2:0] {
      OP_NONE  = 3'd0,
      OP_MULT  = 3'd1,
      OP_MULTU = 3'd2,
      OP_DIV   = 3'd3,
      OP_DIVU  = 3'd4,
      OP_MTHI  = 3'd5,
      OP_MTLO  = 3'd6,
      OP_RSVD  = 3'd7
   } mdu_op_e;

   localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CNT_W   = $clog2(MAX_CYC + 1);

   localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
   localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
   localparam logic [WIDTH-1:0] MIN_NEG   = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;
   logic [WIDTH-1:0] pend_hi_q, pend_hi_d;
   logic [WIDTH-1:0] pend_lo_q, pend_lo_d;
   logic             pend_wr_q, pend_wr_d;

   logic [2*WIDTH-1:0] prod_s;
   logic [2*WIDTH-1:0] prod_u;
   logic [WIDTH-1:0]   sdiv_b;
   logic [WIDTH-1:0]   udiv_b;
   logic [WIDTH-1:0]   quo_s;
   logic [WIDTH-1:0]   rem_s;
   logic [WIDTH-1:0]   quo_u;
   logic [WIDTH-1:0]   rem_u;
   logic               div_by_zero;
   logic               div_ovf;
   logic               accept;

   // Full-width arithmetic on the current operands; only captured on an accept edge.
   always_comb begin
      prod_s      = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
      prod_u      = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      div_by_zero = (b == '0);
      div_ovf     = (a == MIN_NEG) && (b == '1);
      // Dividing by 1 instead of -1 in the overflow case yields exactly the required
      // quotient (most-negative) and remainder (0) without ever forming +2^(W-1).
      // A zero divisor is also swapped for 1 so no divide-by-zero is evaluated;
      // that result is thrown away by pend_wr.
      sdiv_b      = (div_by_zero || div_ovf) ? ONE : b;
      udiv_b      = div_by_zero ? ONE : b;
      quo_s       = $signed(a) / $signed(sdiv_b);
      rem_s       = $signed(a) % $signed(sdiv_b);
      quo_u       = a / udiv_b;
      rem_u       = a % udiv_b;
   end

   // Next-state: count down, commit pending result on 1->0, accept a new op only when idle.
   always_comb begin
      cnt_d     = cnt_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_wr_d = pend_wr_q;
      accept    = start && (cnt_q == '0);

      if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_ONE;
         if ((cnt_q == CNT_ONE) && pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
         end
      end

      if (accept) begin
         case (mdu_op)
            OP_MULT: begin
               pend_hi_d = prod_s[2*WIDTH-1:WIDTH];
               pend_lo_d = prod_s[WIDTH-1:0];
               pend_wr_d = 1'b1;
               cnt_d     = MULT_LOAD;
            end
            OP_MULTU: begin
               pend_hi_d = prod_u[2*WIDTH-1:WIDTH];
               pend_lo_d = prod_u[WIDTH-1:0];
               pend_wr_d = 1'b1;
               cnt_d     = MULT_LOAD;
            end
            OP_DIV: begin
               pend_hi_d = rem_s;
               pend_lo_d = quo_s;
               pend_wr_d = !div_by_zero;
               cnt_d     = DIV_LOAD;
            end
            OP_DIVU: begin
               pend_hi_d = rem_u;
               pend_lo_d = quo_u;
               pend_wr_d = !div_by_zero;
               cnt_d     = DIV_LOAD;
            end
            OP_MTHI: hi_d = a;
            OP_MTLO: lo_d = a;
            default: ;
         endcase
      end
   end

   // State registers; reset discards any in-flight result and overrides a same-edge start.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         hi_q      <= '0;
         lo_q      <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_wr_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_wr_q <= pend_wr_d;
      end
   end

   assign busy    = (cnt_q != '0);
   assign hi      = hi_q;
   assign lo      = lo_q;
   assign rd_data = rd_sel ? hi_q : lo_q;

endmodule

// File: tb/tb_mdu_hilo_unit.sv
// Self-checking bench for mdu_hilo_unit: directed cases plus random ops against a 64-bit arithmetic model.
// Latency: checks busy every cycle of an op and hi/lo in the first idle cycle.
// Backpressure: exercises ignored starts while busy and reset during an operation.
module tb_mdu_hilo_unit;

   localparam int W      = 32;
   localparam int MULT_N = 5;
   localparam int DIV_N  = 10;

   localparam logic [2:0] OP_NONE  = 3'd0;
   localparam logic [2:0] OP_MULT  = 3'd1;
   localparam logic [2:0] OP_MULTU = 3'd2;
   localparam logic [2:0] OP_DIV   = 3'd3;
   localparam logic [2:0] OP_DIVU  = 3'd4;
   localparam logic [2:0] OP_MTHI  = 3'd5;
   localparam logic [2:0] OP_MTLO  = 3'd6;
   localparam logic [2:0] OP_RSVD  = 3'd7;

   logic         clk = 1'b0;
   logic         reset;
   logic         start;
   logic [2:0]   mdu_op;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         rd_sel;
   logic         busy;
   logic [W-1:0] hi;
   logic [W-1:0] lo;
   logic [W-1:0] rd_data;

   int n_checks = 0;
   int n_pass   = 0;

   logic [W-1:0] m_hi;
   logic [W-1:0] m_lo;

   mdu_hilo_unit #(
      .WIDTH       (W),
      .MULT_CYCLES (MULT_N),
      .DIV_CYCLES  (DIV_N)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .start   (start),
      .mdu_op  (mdu_op),
      .a       (a),
      .b       (b),
      .rd_sel  (rd_sel),
      .busy    (busy),
      .hi      (hi),
      .lo      (lo),
      .rd_data (rd_data)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required $finish");
      $fatal(1, "watchdog expired");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Reference: whole results from 64-bit integer arithmetic, no cycle-level detail.
   function automatic void model(input logic [2:0] op, input logic [W-1:0] oa, input logic [W-1:0] ob,
                                 input logic [W-1:0] cur_hi, input logic [W-1:0] cur_lo,
                                 output logic [W-1:0] nh, output logic [W-1:0] nl);
      longint          sa, sb, sp, sq, sr;
      longint unsigned ua, ub, up, uq, ur;
      sa = longint'($signed(oa));
      sb = longint'($signed(ob));
      ua = {32'd0, oa};
      ub = {32'd0, ob};
      nh = cur_hi;
      nl = cur_lo;
      case (op)
         OP_MULT: begin
            sp = sa * sb;
            nh = sp[63:32];
            nl = sp[31:0];
         end
         OP_MULTU: begin
            up = ua * ub;
            nh = up[63:32];
            nl = up[31:0];
         end
         OP_DIV: if (ob != 0) begin
            sq = sa / sb;
            sr = sa % sb;
            nh = sr[31:0];
            nl = sq[31:0];
         end
         OP_DIVU: if (ob != 0) begin
            uq = ua / ub;
            ur = ua % ub;
            nh = ur[31:0];
            nl = uq[31:0];
         end
         OP_MTHI: nh = oa;
         OP_MTLO: nl = oa;
         default: ;
      endcase
   endfunction

   function automatic int op_cycles(input logic [2:0] op);
      if (op == OP_MULT || op == OP_MULTU) return MULT_N;
      if (op == OP_DIV || op == OP_DIVU) return DIV_N;
      return 0;
   endfunction

   // Issue one op in an idle cycle, verify busy window, held values, and final hi/lo.
   task automatic run_op(input string tag, input logic [2:0] op, input logic [W-1:0] oa, input logic [W-1:0] ob);
      logic [W-1:0] eh, el;
      int n;
      model(op, oa, ob, m_hi, m_lo, eh, el);
      n      = op_cycles(op);
      start  = 1'b1;
      mdu_op = op;
      a      = oa;
      b      = ob;
      step();
      start  = 1'b0;
      mdu_op = OP_NONE;
      for (int i = 0; i < n; i++) begin
         check({tag, "_busy"}, {31'd0, busy}, 32'd1);
         check({tag, "_hold_hi"}, hi, m_hi);
         check({tag, "_hold_lo"}, lo, m_lo);
         step();
      end
      check({tag, "_idle"}, {31'd0, busy}, 32'd0);
      check({tag, "_hi"}, hi, eh);
      check({tag, "_lo"}, lo, el);
      rd_sel = 1'b1;
      #1;
      check({tag, "_rd_hi"}, rd_data, eh);
      rd_sel = 1'b0;
      #1;
      check({tag, "_rd_lo"}, rd_data, el);
      m_hi = eh;
      m_lo = el;
   endtask

   initial begin
      logic [W-1:0] eh, el, ra, rb;
      logic [2:0]   rop;
      int           pick;

      reset  = 1'b1;
      start  = 1'b0;
      mdu_op = OP_NONE;
      a      = '0;
      b      = '0;
      rd_sel = 1'b0;
      m_hi   = '0;
      m_lo   = '0;
      step();
      step();
      reset = 1'b0;
      check("reset_busy", {31'd0, busy}, 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);

      // Directed cases
      run_op("mult", OP_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
      check("mult_const_hi", hi, 32'hFFFF_FFFF);
      check("mult_const_lo", lo, 32'hFFFF_FFFE);
      run_op("multu", OP_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
      check("multu_const_hi", hi, 32'h0000_0001);
      check("multu_const_lo", lo, 32'hFFFF_FFFE);
      run_op("div", OP_DIV, 32'hFFFF_FFF9, 32'h0000_0002);
      check("div_const_hi", hi, 32'hFFFF_FFFF);
      check("div_const_lo", lo, 32'hFFFF_FFFD);
      run_op("mthi", OP_MTHI, 32'h0000_0011, 32'h0);
      run_op("mtlo", OP_MTLO, 32'h0000_0022, 32'h0);
      run_op("divu0", OP_DIVU, 32'h0000_0007, 32'h0);
      check("divu0_const_hi", hi, 32'h0000_0011);
      check("divu0_const_lo", lo, 32'h0000_0022);
      run_op("div_ovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
      check("div_ovf_const_hi", hi, 32'h0000_0000);
      check("div_ovf_const_lo", lo, 32'h8000_0000);
      run_op("divu_big", OP_DIVU, 32'h8000_0000, 32'hFFFF_FFFF);
      run_op("none", OP_NONE, 32'hDEAD_BEEF, 32'h1);
      run_op("rsvd", OP_RSVD, 32'hDEAD_BEEF, 32'h1);

      // mtlo held on start for the whole busy window, including the commit edge: ignored
      model(OP_MULT, 32'h0000_1234, 32'h0000_0010, m_hi, m_lo, eh, el);
      start  = 1'b1;
      mdu_op = OP_MULT;
      a      = 32'h0000_1234;
      b      = 32'h0000_0010;
      step();
      mdu_op = OP_MTLO;
      a      = 32'h0000_0055;
      for (int i = 0; i < MULT_N; i++) begin
         check("ign_busy", {31'd0, busy}, 32'd1);
         step();
      end
      start  = 1'b0;
      mdu_op = OP_NONE;
      check("ign_idle", {31'd0, busy}, 32'd0);
      check("ign_hi", hi, eh);
      check("ign_lo", lo, el);
      m_hi = eh;
      m_lo = el;
      // Back-to-back: accepted in the first idle cycle
      run_op("b2b_mthi", OP_MTHI, 32'h0000_0077, 32'h0);

      // Reset during busy cycle 3: result discarded, never committed later
      start  = 1'b1;
      mdu_op = OP_MULT;
      a      = 32'h0000_0003;
      b      = 32'h0000_0004;
      step();
      start  = 1'b0;
      mdu_op = OP_NONE;
      check("rst_mid_busy1", {31'd0, busy}, 32'd1);
      step();
      check("rst_mid_busy2", {31'd0, busy}, 32'd1);
      step();
      check("rst_mid_busy3", {31'd0, busy}, 32'd1);
      reset = 1'b1;
      step();
      reset = 1'b0;
      m_hi  = '0;
      m_lo  = '0;
      for (int i = 0; i < MULT_N + 2; i++) begin
         check("rst_mid_busy", {31'd0, busy}, 32'd0);
         check("rst_mid_hi", hi, 32'd0);
         check("rst_mid_lo", lo, 32'd0);
         step();
      end

      // Reset beats a same-edge start
      reset  = 1'b1;
      start  = 1'b1;
      mdu_op = OP_MTHI;
      a      = 32'h0000_ABCD;
      step();
      reset  = 1'b0;
      start  = 1'b0;
      mdu_op = OP_NONE;
      check("rst_start_hi", hi, 32'd0);
      check("rst_start_busy", {31'd0, busy}, 32'd0);

      // Random ops with biased corner operands
      for (int k = 0; k < 40; k++) begin
         rop  = 3'($urandom_range(0, 7));
         ra   = $urandom;
         rb   = $urandom;
         pick = $urandom_range(0, 9);
         if (pick == 0) rb = '0;
         if (pick == 1) rb = '1;
         if (pick == 2) begin
            ra = 32'h8000_0000;
            rb = '1;
         end
         if (pick == 3) rb = 32'(ra[7:0]);
         run_op("rand", rop, ra, rb);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/mdu_hilo_unit.md
Name: mdu_hilo_unit

Overview:
- Multi-cycle multiply/divide unit with HI/LO registers for the pipelined MIPS datapath; the sequential successor to the combinational ALU-op decoder.
- Decodes a compact MDU operation code, runs mult/multu/div/divu over a parametrised cycle count, and holds results in HI/LO.
- Exports a busy flag for the hazard unit and a read port for mfhi/mflo in the E stage.

Parameters:
- WIDTH, 32, operand and HI/LO width.
- MULT_CYCLES, 5, busy cycles for mult/multu (must be >= 1).
- DIV_CYCLES, 10, busy cycles for div/divu (must be >= 1).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-high reset.
- start  input  1  issue mdu_op this cycle.
- mdu_op  input  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- a  input  WIDTH  rs operand.
- b  input  WIDTH  rt operand.
- rd_sel  input  1  0 selects LO, 1 selects HI on rd_data.
- busy  output  1  high while an operation is in flight.
- hi  output  WIDTH  HI register.
- lo  output  WIDTH  LO register.
- rd_data  output  WIDTH  combinational mux: rd_sel ? hi : lo.

Behaviour:
- Reset (sync, clk edge with reset=1): hi=0, lo=0, busy=0, cycle counter=0, pending result discarded. Applies mid-operation; reset wins over start on the same edge.
- Accept: an op is accepted on an edge where start=1 && busy=0 && reset=0. If start=1 while busy=1, the op is ignored; there is no queueing, and upstream stalls on busy.
- mult/multu/div/divu on accept:
  - Compute the full result from a/b sampled at the accept edge, into internal pending registers.
  - Load the counter with MULT_CYCLES or DIV_CYCLES.
- Counter: decrements by 1 each edge while nonzero. busy = (counter != 0), a registered-equivalent signal, so busy is high exactly N cycles starting the cycle after the accept edge.
- Commit: on the edge where the counter goes 1->0, pending values are written to hi/lo. Results are visible in the first cycle busy=0. Before that edge, hi/lo hold their old values.
- mthi/mtlo: on accept, write a to hi (resp. lo) on that edge. busy is unaffected; the effect is visible the next cycle.
- mult: signed 2*WIDTH product; hi = upper WIDTH bits, lo = lower WIDTH bits.
- multu: the same, unsigned.
- div (signed):
  - lo = quotient, truncated toward zero; hi = remainder, with the sign of the dividend.
  - Special case a = most-negative, b = -1: lo = most-negative, hi = 0.
- divu: unsigned quotient/remainder.
- Divide by zero (div/divu with b=0): busy still runs DIV_CYCLES; hi/lo remain unchanged at commit.
- mdu_op 0 or 7 with start=1: no effect, busy stays 0.
- Back-to-back: a new op may be accepted on the same edge busy would read 0, i.e. the cycle after commit, never the commit edge itself.

Test Plan:
- Reset then mult a=0xFFFFFFFF, b=0x00000002:
  - busy=1 for exactly 5 cycles.
  - Then hi=0xFFFFFFFF, lo=0xFFFFFFFE.
  - rd_sel=1 gives 0xFFFFFFFF.
- multu a=0xFFFFFFFF, b=0x00000002 -> hi=0x00000001, lo=0xFFFFFFFE after 5 busy cycles; hi/lo hold their prior values while busy=1.
- div a=0xFFFFFFF9 (-7), b=2:
  - busy high for 10 cycles.
  - Then lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1).
- divu a=7, b=0 with hi=0x11, lo=0x22 preloaded via mthi/mtlo:
  - busy high for 10 cycles.
  - hi=0x11, lo=0x22 unchanged.
- div a=0x80000000, b=0xFFFFFFFF -> lo=0x80000000, hi=0 after 10 busy cycles.
- Two mid-operation cases:
  - Start mult, then assert start with mtlo a=0x55 during busy: mtlo ignored, mult result committed normally.
  - Start mult, then assert reset at busy cycle 3: next cycle busy=0, hi=lo=0, no later commit.
